// File: rtl/uart_rx_buffer_ctrl.sv
// UART receive buffer controller: captures each word-ready pulse once,
// stores data plus framing flag in a small FWFT FIFO for the host.
module uart_rx_buffer_ctrl #(
    parameter int word_size  = 8,
    parameter int addr_width = 2
) (
    input  logic                  Sample_clk,
    input  logic                  rst,
    input  logic [word_size-1:0]  Rx_datareg,
    input  logic                  rx_word_ready,
    input  logic                  rx_err_overrun,
    input  logic                  rx_err_frame,
    output logic                  read_not_ready_in,
    output logic [word_size-1:0]  host_data,
    output logic                  host_frame_err,
    output logic                  host_valid,
    input  logic                  host_rd,
    output logic [addr_width:0]   fifo_count,
    output logic                  overrun_sticky,
    input  logic                  clr_errors
);

    localparam int DEPTH = 2 ** addr_width;
    localparam logic [addr_width:0] FULL_CNT = (addr_width + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STORE    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t                r_state;
    logic [addr_width-1:0] r_wr_ptr;
    logic [addr_width-1:0] r_rd_ptr;
    logic [addr_width:0]   r_count;
    logic                  r_overrun;

    logic [word_size-1:0]  r_mem_data [DEPTH];
    logic                  r_mem_fe   [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_set_err;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_pop     = host_rd & ~w_empty;
    // A full FIFO still accepts the word when the head leaves this cycle
    assign w_push    = (r_state == STORE) & (~w_full | host_rd);
    assign w_drop    = (r_state == STORE) & w_full & ~host_rd;
    assign w_set_err = rx_err_overrun | w_drop;

    always_ff @(posedge Sample_clk) begin
        if (rst) begin
            r_state   <= WAIT_LOW;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_word_ready) begin
                        r_state <= STORE;
                    end
                end
                STORE: begin
                    r_state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!rx_word_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= WAIT_LOW;
                end
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + addr_width'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + addr_width'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (addr_width + 1)'(1);
                2'b01:   r_count <= r_count - (addr_width + 1)'(1);
                default: r_count <= r_count;
            endcase

            if (w_set_err) begin
                r_overrun <= 1'b1;
            end else if (clr_errors) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge Sample_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= Rx_datareg;
            r_mem_fe[r_wr_ptr]   <= rx_err_frame;
        end
    end

    assign read_not_ready_in = w_full;
    assign host_valid        = ~w_empty;
    assign host_data         = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign host_frame_err    = w_empty ? 1'b0 : r_mem_fe[r_rd_ptr];
    assign fifo_count        = r_count;
    assign overrun_sticky    = r_overrun;

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Bench for uart_rx_buffer_ctrl: directed steps plus random traffic,
// checked against a queue-based transaction model.
module tb_uart_rx_buffer_ctrl;

    logic       Sample_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] Rx_datareg = '0;
    logic       rx_word_ready = 1'b0;
    logic       rx_err_overrun = 1'b0;
    logic       rx_err_frame = 1'b0;
    logic       read_not_ready_in;
    logic [7:0] host_data;
    logic       host_frame_err;
    logic       host_valid;
    logic       host_rd = 1'b0;
    logic [2:0] fifo_count;
    logic       overrun_sticky;
    logic       clr_errors = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       fe;
    } ent_t;

    ent_t q[$];
    logic m_sticky = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 Sample_clk = ~Sample_clk;

    uart_rx_buffer_ctrl #(.word_size(8), .addr_width(2)) dut (
        .Sample_clk       (Sample_clk),
        .rst              (rst),
        .Rx_datareg       (Rx_datareg),
        .rx_word_ready    (rx_word_ready),
        .rx_err_overrun   (rx_err_overrun),
        .rx_err_frame     (rx_err_frame),
        .read_not_ready_in(read_not_ready_in),
        .host_data        (host_data),
        .host_frame_err   (host_frame_err),
        .host_valid       (host_valid),
        .host_rd          (host_rd),
        .fifo_count       (fifo_count),
        .overrun_sticky   (overrun_sticky),
        .clr_errors       (clr_errors)
    );

    task automatic tick();
        @(posedge Sample_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] ed;
        logic       ef;
        ed = (q.size() > 0) ? q[0].d : 8'h00;
        ef = (q.size() > 0) ? q[0].fe : 1'b0;
        chk({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
        chk({tag, ".valid"}, 32'(host_valid), 32'(q.size() != 0));
        chk({tag, ".nrdy"}, 32'(read_not_ready_in), 32'(q.size() == 4));
        chk({tag, ".ovr"}, 32'(overrun_sticky), 32'(m_sticky));
        chk({tag, ".data"}, 32'(host_data), 32'(ed));
        chk({tag, ".fe"}, 32'(host_frame_err), 32'(ef));
    endtask

    // Controller must be idle (rx_word_ready seen low) before calling
    task automatic send_word(input logic [7:0] d, input logic fe,
                             input int hold, input logic rd_in_store,
                             input string tag);
        Rx_datareg    = d;
        rx_err_frame  = fe;
        rx_word_ready = 1'b1;
        tick();
        check_all({tag, ".n"});
        host_rd = rd_in_store;
        tick();
        host_rd = 1'b0;
        if (rd_in_store && q.size() > 0) void'(q.pop_front());
        if (q.size() < 4) q.push_back('{d: d, fe: fe});
        else m_sticky = 1'b1;
        check_all({tag, ".n1"});
        for (int i = 2; i < hold; i++) tick();
        rx_word_ready = 1'b0;
        rx_err_frame  = 1'b0;
        tick();
        check_all({tag, ".end"});
    endtask

    task automatic pop(input string tag);
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        q.delete();
        m_sticky = 1'b0;
    endtask

    initial begin
        // reset with rx_word_ready already high: must not capture
        rx_word_ready = 1'b1;
        Rx_datareg    = 8'h99;
        do_reset();
        check_all("rst");
        tick();
        tick();
        tick();
        check_all("rst_hold");
        rx_word_ready = 1'b0;
        tick();
        check_all("rst_low");

        send_word(8'hA5, 1'b0, 5, 1'b0, "single");
        chk("single.head", 32'(host_data), 32'h A5);
        pop("single.pop");

        send_word(8'h11, 1'b0, 2, 1'b0, "f1");
        send_word(8'h22, 1'b0, 3, 1'b0, "f2");
        send_word(8'h33, 1'b0, 2, 1'b0, "f3");
        send_word(8'h44, 1'b0, 2, 1'b0, "f4");
        send_word(8'h55, 1'b0, 2, 1'b0, "f5drop");
        for (int i = 0; i < 4; i++) pop("fpop");
        clr_errors = 1'b1;
        tick();
        clr_errors = 1'b0;
        m_sticky = 1'b0;
        check_all("clr0");

        send_word(8'h11, 1'b0, 2, 1'b0, "s1");
        send_word(8'h22, 1'b0, 2, 1'b0, "s2");
        send_word(8'h33, 1'b0, 2, 1'b0, "s3");
        send_word(8'h44, 1'b0, 2, 1'b0, "s4");
        send_word(8'h55, 1'b0, 2, 1'b1, "s5rdwr");
        for (int i = 0; i < 4; i++) pop("spop");

        send_word(8'h3C, 1'b1, 3, 1'b0, "fe1");
        send_word(8'h5A, 1'b0, 3, 1'b0, "fe0");
        pop("fepop1");
        pop("fepop2");

        rx_err_overrun = 1'b1;
        tick();
        rx_err_overrun = 1'b0;
        m_sticky = 1'b1;
        check_all("ovr_set");
        rx_err_overrun = 1'b1;
        clr_errors     = 1'b1;
        tick();
        rx_err_overrun = 1'b0;
        clr_errors     = 1'b0;
        check_all("ovr_both");
        clr_errors = 1'b1;
        tick();
        clr_errors = 1'b0;
        m_sticky = 1'b0;
        check_all("ovr_clr");

        // random traffic across pointer wrap
        for (int w = 0; w < 10; w++) begin
            send_word(8'($urandom), 1'($urandom), $urandom_range(2, 5),
                      1'($urandom), "rnd");
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                if ($urandom_range(0, 1) == 1) pop("rndpop");
                else begin
                    tick();
                    check_all("rndidle");
                end
            end
        end
        while (q.size() > 0) pop("drain");

        // reset mid-operation discards entries
        send_word(8'h77, 1'b0, 2, 1'b0, "pre_rst");
        Rx_datareg    = 8'h88;
        rx_word_ready = 1'b1;
        tick();
        do_reset();
        check_all("midrst");
        rx_word_ready = 1'b0;
        tick();
        check_all("midrst_low");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
